// File: rtl/qc_parity_accumulator_pkg.sv
// Shared types and elaboration helpers for the QC-LDPC parity accumulator.
package qc_enc_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    // Ceiling log2 with a one-bit floor so that every counter has a real register.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

    function automatic int bpb(input int m, input int lm);
        return m / lm;
    endfunction

endpackage

// File: rtl/qc_parity_accumulator_if.sv
// Message-beat input and parity-word output channels of the accumulator.
interface qc_parity_accumulator_if #(
    parameter int M    = 6,
    parameter int LM   = 2,
    parameter int NCOL = 2
) ();
    logic                in_valid;
    logic                in_ready;
    logic [LM-1:0]       in_msg;
    logic [NCOL*M-1:0]   in_f;
    logic                in_last;
    logic                par_valid;
    logic                par_ready;
    logic [NCOL*M-1:0]   par_data;
    logic                err_len;

    modport master (
        output in_valid, in_msg, in_f, in_last, par_ready,
        input  in_ready, par_valid, par_data, err_len
    );

    modport slave (
        input  in_valid, in_msg, in_f, in_last, par_ready,
        output in_ready, par_valid, par_data, err_len
    );
endinterface

// File: rtl/qc_parity_accumulator_mac.sv
// One circulant column: LM message bits times the rotated first row, giving an M-bit partial product.
module circulant_mac_slice
    import qc_enc_pkg::*;
#(
    parameter int M  = 6,
    parameter int LM = 2,
    localparam int OFF_W = clog2(M),
    localparam int IDX_W = clog2(2 * M)
) (
    input  logic [M-1:0]     f_i,
    input  logic [LM-1:0]    msg_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [M-1:0]     pp_o
);
    // off+j+k never reaches 2M, so a doubled row replaces the modulo.
    logic [2*M-1:0] f_dbl;
    assign f_dbl = {f_i, f_i};

    for (genvar gi = 0; gi < M; gi++) begin : g_bit
        logic [LM-1:0] terms;
        for (genvar gj = 0; gj < LM; gj++) begin : g_term
            logic [IDX_W-1:0] idx;
            assign idx         = IDX_W'(off_i) + IDX_W'(gi + gj);
            assign terms[gj]   = msg_i[gj] & f_dbl[idx];
        end
        assign pp_o[gi] = ^terms;
    end

endmodule

// File: rtl/qc_parity_accumulator.sv
// Accumulates NBLK blocks of message beats against NCOL circulant columns and hands out the parity word.
module qc_parity_accumulator
    import qc_enc_pkg::*;
#(
    parameter int M    = 6,
    parameter int LM   = 2,
    parameter int NCOL = 2,
    parameter int NBLK = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    qc_parity_accumulator_if.slave  bus
);
    localparam int BPB    = bpb(M, LM);
    localparam int BEAT_W = clog2(BPB);
    localparam int BLK_W  = clog2(NBLK);
    localparam int OFF_W  = clog2(M);
    localparam int W      = NCOL * M;

    if ((M % LM) != 0) begin : g_bad_params
        $error("qc_parity_accumulator: M must be a multiple of LM");
    end

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [W-1:0]      f_q, f_d;
    logic [W-1:0]      par_data_q, par_data_d;
    logic              par_valid_q, par_valid_d;
    logic              err_len_q, err_len_d;

    logic [OFF_W-1:0]  off;
    logic [W-1:0]      f_use;
    logic [W-1:0]      partial;
    logic              accept, last_beat, final_beat;

    assign off        = OFF_W'(int'(beat_q) * LM);
    // First rows are only sampled on a block's first beat and reused for the rest of it.
    assign f_use      = (beat_q == '0) ? bus.in_f : f_q;
    assign accept     = bus.in_valid && bus.in_ready;
    assign last_beat  = (beat_q == BEAT_W'(BPB - 1));
    assign final_beat = last_beat && (blk_q == BLK_W'(NBLK - 1));

    for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
        circulant_mac_slice #(.M(M), .LM(LM)) u_mac (
            .f_i   (f_use[gi*M +: M]),
            .msg_i (bus.in_msg),
            .off_i (off),
            .pp_o  (partial[gi*M +: M])
        );
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.par_valid = par_valid_q;
    assign bus.par_data  = par_data_q;
    assign bus.err_len   = err_len_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        blk_d       = blk_q;
        acc_d       = acc_q;
        f_d         = f_q;
        par_data_d  = par_data_q;
        par_valid_d = par_valid_q;
        err_len_d   = 1'b0;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (beat_q == '0) f_d = bus.in_f;
                    if (final_beat) begin
                        par_data_d  = acc_q ^ partial;
                        par_valid_d = 1'b1;
                        acc_d       = '0;
                        beat_d      = '0;
                        blk_d       = '0;
                        state_d     = OUT;
                        err_len_d   = !bus.in_last;
                    end else if (bus.in_last) begin
                        // Early in_last: source and counters disagree, drop the frame.
                        acc_d     = '0;
                        beat_d    = '0;
                        blk_d     = '0;
                        err_len_d = 1'b1;
                    end else begin
                        acc_d = acc_q ^ partial;
                        if (last_beat) begin
                            beat_d = '0;
                            blk_d  = blk_q + BLK_W'(1);
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
            end
            OUT: begin
                if (bus.par_ready) begin
                    par_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            beat_q      <= '0;
            blk_q       <= '0;
            acc_q       <= '0;
            f_q         <= '0;
            par_data_q  <= '0;
            par_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            blk_q       <= blk_d;
            acc_q       <= acc_d;
            f_q         <= f_d;
            par_data_q  <= par_data_d;
            par_valid_q <= par_valid_d;
            err_len_q   <= err_len_d;
        end
    end

endmodule

// File: tb/tb_qc_parity_accumulator.sv
// Directed and random frames for the parity accumulator (M=6, LM=2, NCOL=2, NBLK=2).
module tb_qc_parity_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    qc_parity_accumulator_if #(.M(6), .LM(2), .NCOL(2)) bus ();

    qc_parity_accumulator #(.M(6), .LM(2), .NCOL(2), .NBLK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parity from the codeword definition: bit k of column c = XOR over blocks and message bits i of msg[i] & f[(i+k)%6].
    function automatic logic [11:0] ref_par(input logic [11:0] msg, input logic [11:0] fb0, input logic [11:0] fb1);
        logic [11:0] p;
        logic [11:0] fb;
        p = '0;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 6; k++)
                for (int b = 0; b < 2; b++) begin
                    fb = (b == 0) ? fb0 : fb1;
                    for (int i = 0; i < 6; i++)
                        p[c*6+k] = p[c*6+k] ^ (msg[6*b+i] & fb[c*6 + ((i + k) % 6)]);
                end
        return p;
    endfunction

    task automatic drive_beat(input logic [1:0] m, input logic [11:0] f, input logic last);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_msg   = m;
        bus.in_f     = f;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_msg   = '0;
    endtask

    task automatic run_frame(input logic [11:0] msg, input logic [11:0] fb0, input logic [11:0] fb1,
                             input logic [11:0] fjunk, input int last_at, input int nbeats);
        for (int b = 0; b < nbeats; b++)
            drive_beat(msg[2*b +: 2], (b % 3 != 0) ? fjunk : ((b < 3) ? fb0 : fb1), b == last_at);
    endtask

    task automatic expect_parity(input string tag, input logic [11:0] exp_data, input logic exp_err);
        check({tag, "_valid"}, {31'd0, bus.par_valid}, 32'd1);
        check({tag, "_data"}, {20'd0, bus.par_data}, {20'd0, exp_data});
        check({tag, "_err"}, {31'd0, bus.err_len}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
        bus.par_ready = 1'b1;
        @(posedge clk); #1;
        bus.par_ready = 1'b0;
        check({tag, "_done"}, {31'd0, bus.par_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [11:0] rm, rf0, rf1;
        bus.in_valid  = 1'b0;
        bus.in_msg    = '0;
        bus.in_f      = '0;
        bus.in_last   = 1'b0;
        bus.par_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_par_valid", {31'd0, bus.par_valid}, 32'd0);
        check("rst_par_data", {20'd0, bus.par_data}, 32'd0);
        check("rst_err_len", {31'd0, bus.err_len}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Case 1: single message bit at position 1 against f=000001.
        run_frame(12'h002, 12'h001, 12'h001, 12'h000, 5, 6);
        expect_parity("c1", 12'h020, 1'b0);

        // Both columns populated.
        run_frame(12'h001, 12'h081, 12'h000, 12'h000, 5, 6);
        expect_parity("c1b", 12'h081, 1'b0);

        // Case 2: all-ones block, then all-ones in both blocks cancels.
        run_frame(12'h03F, 12'h001, 12'h001, 12'h000, 5, 6);
        expect_parity("c2a", 12'h03F, 1'b0);
        run_frame(12'hFFF, 12'h001, 12'h001, 12'h000, 5, 6);
        expect_parity("c2b", 12'h000, 1'b0);

        // Case 3: in_f driven on non-first beats must be ignored.
        run_frame(12'h002, 12'h001, 12'h001, 12'hFFF, 5, 6);
        expect_parity("c3", 12'h020, 1'b0);

        // Case 4: held parity under backpressure, beats offered meanwhile are ignored.
        run_frame(12'h002, 12'h001, 12'h001, 12'h000, 5, 6);
        bus.in_valid = 1'b1;
        bus.in_msg   = 2'b11;
        bus.in_f     = 12'hFFF;
        for (int i = 0; i < 5; i++) begin
            check("c4_hold_valid", {31'd0, bus.par_valid}, 32'd1);
            check("c4_hold_data", {20'd0, bus.par_data}, 32'h020);
            check("c4_hold_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        expect_parity("c4", 12'h020, 1'b0);
        run_frame(12'h03F, 12'h001, 12'h001, 12'h000, 5, 6);
        expect_parity("c4_b2b", 12'h03F, 1'b0);

        // Case 5: early in_last aborts, then a clean frame, then a frame with no in_last.
        run_frame(12'h03F, 12'h001, 12'h001, 12'h000, 2, 3);
        check("c5_abort_err", {31'd0, bus.err_len}, 32'd1);
        check("c5_abort_valid", {31'd0, bus.par_valid}, 32'd0);
        @(posedge clk); #1;
        check("c5_err_pulse", {31'd0, bus.err_len}, 32'd0);
        check("c5_no_par", {31'd0, bus.par_valid}, 32'd0);
        run_frame(12'h002, 12'h001, 12'h001, 12'h000, 5, 6);
        expect_parity("c5_after", 12'h020, 1'b0);
        run_frame(12'h03F, 12'h001, 12'h001, 12'h000, -1, 6);
        expect_parity("c5_nolast", 12'h03F, 1'b1);

        // Case 6: reset mid-frame and while parity is pending.
        run_frame(12'h03F, 12'h001, 12'h001, 12'h000, -1, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("c6_mid_valid", {31'd0, bus.par_valid}, 32'd0);
        check("c6_mid_ready", {31'd0, bus.in_ready}, 32'd1);
        run_frame(12'h002, 12'h001, 12'h001, 12'h000, 5, 6);
        expect_parity("c6_fresh", 12'h020, 1'b0);
        run_frame(12'h03F, 12'h001, 12'h001, 12'h000, 5, 6);
        check("c6_out_valid", {31'd0, bus.par_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("c6_out_cleared", {31'd0, bus.par_valid}, 32'd0);
        check("c6_out_data", {20'd0, bus.par_data}, 32'd0);
        check("c6_out_ready", {31'd0, bus.in_ready}, 32'd1);
        run_frame(12'h001, 12'h081, 12'h000, 12'h000, 5, 6);
        expect_parity("c6_after", 12'h081, 1'b0);

        // Random frames against the reference parity.
        for (int t = 0; t < 8; t++) begin
            rm  = 12'($urandom);
            rf0 = 12'($urandom);
            rf1 = 12'($urandom);
            run_frame(rm, rf0, rf1, 12'($urandom), 5, 6);
            expect_parity("rand", ref_par(rm, rf0, rf1), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
